// File: rtl/serial_arith_pkg.sv
// Types and defaults shared by the bit-serial adder and subtractor.
package serial_arith_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOADED,
    SHIFT,
    DONE
  } state_e;

endpackage

// File: rtl/full_subtractor_bit.sv
// Combinational one-bit difference/borrow cell.
module full_subtractor_bit (
  input  logic x_i,
  input  logic y_i,
  input  logic bin_i,
  output logic diff_o,
  output logic bout_o
);

  always_comb begin
    diff_o = x_i ^ y_i ^ bin_i;
    bout_o = (~x_i & y_i) | (~(x_i ^ y_i) & bin_i);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: d = a - b - bin over WIDTH cycles, with borrow and signed-overflow flags.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] d,
  output logic             BF,
  output logic             OF,
  output logic             busy,
  output logic             done
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sa_q, sa_d, sb_q, sb_d, res_q, res_d, dout_q, dout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               brw_q, brw_d, amsb_q, amsb_d, bmsb_q, bmsb_d;
  logic               bf_q, bf_d, of_q, of_d, done_q, done_d;
  logic               diff_bit, brw_next, last_bit;

  full_subtractor_bit u_cell (
    .x_i    (sa_q[0]),
    .y_i    (sb_q[0]),
    .bin_i  (brw_q),
    .diff_o (diff_bit),
    .bout_o (brw_next)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    dout_d  = dout_q;
    bf_d    = bf_q;
    of_d    = of_q;
    done_d  = done_q;

    // A high load wins in every state; LOADED and SHIFT otherwise step one bit.
    if (load) begin
      state_d = LOADED;
      sa_d    = a;
      sb_d    = b;
      brw_d   = bin;
      res_d   = '0;
      cnt_d   = '0;
      amsb_d  = a[WIDTH-1];
      bmsb_d  = b[WIDTH-1];
      done_d  = 1'b0;
    end else begin
      case (state_q)
        LOADED, SHIFT: begin
          sa_d  = {1'b0, sa_q[WIDTH-1:1]};
          sb_d  = {1'b0, sb_q[WIDTH-1:1]};
          brw_d = brw_next;
          res_d = {diff_bit, res_q[WIDTH-1:1]};
          if (last_bit) begin
            state_d = DONE;
            dout_d  = {diff_bit, res_q[WIDTH-1:1]};
            bf_d    = brw_next;
            of_d    = (amsb_q ^ bmsb_q) & (diff_bit ^ amsb_q);
            done_d  = 1'b1;
          end else begin
            state_d = SHIFT;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      dout_q  <= '0;
      bf_q    <= 1'b0;
      of_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
      dout_q  <= dout_d;
      bf_q    <= bf_d;
      of_q    <= of_d;
      done_q  <= done_d;
    end
  end

  assign d    = dout_q;
  assign BF   = bf_q;
  assign OF   = of_q;
  assign done = done_q;
  assign busy = (state_q == SHIFT);

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: arithmetic reference model plus directed and random operations.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         load  = 1'b0;
  logic         bin   = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic [W-1:0] d;
  logic         BF, OF, busy, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .d     (d),
    .BF    (BF),
    .OF    (OF),
    .busy  (busy),
    .done  (done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: counts edges since the last load and computes the result arithmetically.
  logic [W-1:0] ma = '0, mb = '0, m_d = '0;
  logic         mbin = 1'b0;
  bit           have_ops = 0, m_bf = 0, m_of = 0, m_done = 0, m_busy = 0;
  int           edges = 0, ud = 0, sd = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      have_ops = 0; edges = 0;
      m_d = '0; m_bf = 0; m_of = 0; m_done = 0; m_busy = 0;
    end else if (load) begin
      ma = a; mb = b; mbin = bin;
      have_ops = 1; edges = 0; m_done = 0; m_busy = 0;
    end else if (have_ops) begin
      edges++;
      if (edges == W) begin
        ud = int'(ma) - int'(mb) - int'(mbin);
        sd = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
        m_d    = W'(ud);
        m_bf   = (ud < 0);
        m_of   = (sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1);
        m_done = 1; m_busy = 0; have_ops = 0;
      end else begin
        m_busy = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc_d", 32'(d), 32'(m_d));
      chk("cyc_BF", 32'(BF), 32'(m_bf));
      chk("cyc_OF", 32'(OF), 32'(m_of));
      chk("cyc_done", 32'(done), 32'(m_done));
      chk("cyc_busy", 32'(busy), 32'(m_busy));
    end
  end

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i + 1;
        break;
      end
    end
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                        input int nload, input int abort_after, output int lat);
    @(negedge clk);
    a = ta; b = tb; bin = tbin; load = 1'b1;
    repeat (nload) @(negedge clk);
    load = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    if (abort_after > 0) begin
      repeat (abort_after) @(negedge clk);
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      a = W'($urandom); b = W'($urandom);
    end
    wait_done(lat);
  endtask

  typedef struct {
    logic [W-1:0] a, b;
    logic         bin;
    logic [W-1:0] d;
    logic         bf, of;
  } vec_t;

  vec_t vecs[6] = '{
    '{8'hFF, 8'h22, 1'b0, 8'hDD, 1'b0, 1'b0},
    '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1},
    '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1},
    '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0},
    '{8'h05, 8'h05, 1'b1, 8'hFF, 1'b1, 1'b0},
    '{8'h05, 8'h05, 1'b0, 8'h00, 1'b0, 1'b0}
  };

  initial begin
    int lat;
    logic [W-1:0] dv;

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_d", 32'(d), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    @(posedge clk); #2 rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, 2, 0, lat);
      chk("dir_latency", 32'(lat), 32'(W));
      chk("dir_d", 32'(d), 32'(vecs[i].d));
      chk("dir_BF", 32'(BF), 32'(vecs[i].bf));
      chk("dir_OF", 32'(OF), 32'(vecs[i].of));
    end

    dv = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_d", 32'(d), 32'(dv));
      chk("hold_done", 32'(done), 32'h1);
    end
    a = 8'h03; b = 8'h01; bin = 1'b0; load = 1'b1;
    @(negedge clk);
    chk("reload_done", 32'(done), 32'h0);
    chk("reload_d", 32'(d), 32'(dv));
    load = 1'b0;
    wait_done(lat);
    chk("reload_latency", 32'(lat), 32'(W));
    chk("reload_result", 32'(d), 32'h02);

    @(negedge clk);
    a = 8'h10; b = 8'h01; bin = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_busy", 32'(busy), 32'h1);
    a = 8'h09; b = 8'h03; load = 1'b1;
    @(negedge clk);
    chk("abort_done", 32'(done), 32'h0);
    chk("abort_busy_low", 32'(busy), 32'h0);
    load = 1'b0;
    wait_done(lat);
    chk("abort_latency", 32'(lat), 32'(W));
    chk("abort_d", 32'(d), 32'h06);
    chk("abort_BF", 32'(BF), 32'h0);
    chk("abort_OF", 32'(OF), 32'h0);

    @(negedge clk);
    a = 8'h33; b = 8'h11; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_d", 32'(d), 32'h0);
    chk("arst_BF", 32'(BF), 32'h0);
    chk("arst_OF", 32'(OF), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_done", 32'(done), 32'h0);
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (W + 2) @(negedge clk);
    chk("arst_no_done", 32'(done), 32'h0);

    for (int n = 0; n < 60; n++) begin
      int ab;
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W - 1)) : 0;
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(1, 3)), ab, lat);
      chk("rnd_latency", 32'(lat), 32'(W));
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
